// File: rtl/rf_write_sched_pkg.sv
// Shared types and constants for the register-file write scheduler.
package rf_write_sched_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ADDR_W   = 5;
  localparam int unsigned DEF_DATA_W   = 32;

endpackage

// File: rtl/rf_write_sched_arb.sv
// Two-requester round-robin arbiter with a priority pointer that moves on every grant.
module rr_arb2
  import rf_write_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  // Requester favoured on a tie; becomes the other requester after each grant.
  logic prio;

  always_comb begin
    grant = '0;
    if (en) begin
      if (req[0] && (!req[1] || prio == REQ_A)) begin
        grant[0] = 1'b1;
      end else if (req[1]) begin
        grant[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio <= REQ_A;
    end else if (|grant) begin
      prio <= grant[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/rf_write_sched.sv
// Register-file write port scheduler: clears every register after reset, then
// arbitrates ALU and load writebacks onto a single registered write port.
module rf_write_sched
  import rf_write_sched_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              we3,
  output logic [ADDR_W-1:0] a3,
  output logic [DATA_W-1:0] wd3,
  output logic              init_done
);

  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(NUM_REGS);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   cnt;
  logic [1:0]        grant;
  logic              xfer;
  logic              x_wr;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_data;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state == RUN),
    .req   ({b_valid, a_valid}),
    .grant (grant)
  );

  assign a_ready   = grant[0];
  assign b_ready   = grant[1];
  assign init_done = (state == RUN);

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == CNT_END) begin
      state_nxt = RUN;
    end
  end

  // x0 and out-of-range destinations are accepted but never written.
  always_comb begin
    xfer   = |grant;
    x_addr = grant[1] ? b_addr : a_addr;
    x_data = grant[1] ? b_data : a_data;
    x_wr   = xfer && (x_addr != '0) && ({1'b0, x_addr} < CNT_END);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Counter runs one past the last register so the final clear write is
  // visible for a full cycle before RUN begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      we3 <= 1'b0;
      a3  <= '0;
      wd3 <= '0;
    end else if (state == CLEAR) begin
      if (cnt != CNT_END) begin
        we3 <= 1'b1;
        a3  <= cnt[ADDR_W-1:0];
        wd3 <= '0;
        cnt <= cnt + 1'b1;
      end else begin
        we3 <= 1'b0;
      end
    end else begin
      we3 <= x_wr;
      if (xfer) begin
        a3  <= x_addr;
        wd3 <= x_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed + randomized bench for rf_write_sched with an output scoreboard.
module tb_rf_write_sched;

  localparam int unsigned NR = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          we3, init_done;
  logic [AW-1:0] a3;
  logic [DW-1:0] wd3;

  typedef struct packed {
    logic          we;
    logic          chk;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic          m_prio;
  logic          m_known;
  logic [AW-1:0] m_a3;
  logic [DW-1:0] m_wd3;

  always #5 clk = ~clk;

  rf_write_sched #(
    .NUM_REGS (NR),
    .ADDR_W   (AW),
    .DATA_W   (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .we3       (we3),
    .a3        (a3),
    .wd3       (wd3),
    .init_done (init_done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    wr_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("we3", we3, e.we);
      if (e.chk) begin
        check("a3", a3, e.a);
        check("wd3", wd3, e.d);
      end
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_prio  = 1'b0;
    m_known = 1'b1;
    m_a3    = '0;
    m_wd3   = '0;
  endtask

  task automatic apply_reset(input int unsigned hold);
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    model_reset();
    #1;
    check("rst_we3", we3, 1'b0);
    check("rst_a3", a3, '0);
    check("rst_wd3", wd3, '0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_a_ready", a_ready, 1'b0);
    check("rst_b_ready", b_ready, 1'b0);
    for (int unsigned i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("rst_hold_we3", we3, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called just after reset release; runs n clear cycles (full sequence when n == NR).
  task automatic clear_seq(input int unsigned n, input logic with_req);
    wr_t e;
    a_valid = with_req; a_addr = 5'd9; a_data = 32'h1234;
    b_valid = with_req; b_addr = 5'd8; b_data = 32'h5678;
    for (int unsigned k = 0; k < n; k++) begin
      e = '{we: 1'b1, chk: 1'b1, a: AW'(k), d: '0};
      sb.push_back(e);
      @(posedge clk); #1;
      pop_check();
      check("clr_init_done", init_done, 1'b0);
      check("clr_a_ready", a_ready, 1'b0);
      check("clr_b_ready", b_ready, 1'b0);
    end
    if (n == NR) begin
      a_valid = 1'b0;
      b_valid = 1'b0;
      e = '{we: 1'b0, chk: 1'b1, a: AW'(NR - 1), d: '0};
      sb.push_back(e);
      @(posedge clk); #1;
      pop_check();
      check("init_done_rise", init_done, 1'b1);
      m_a3    = AW'(NR - 1);
      m_wd3   = '0;
      m_known = 1'b1;
    end
  endtask

  task automatic run_cycle(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                           input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    logic          ga, gb;
    logic [AW-1:0] ta;
    logic [DW-1:0] td;
    wr_t           e;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    ga = av && (!bv || m_prio == 1'b0);
    gb = bv && (!av || m_prio == 1'b1);
    check("a_ready", a_ready, ga);
    check("b_ready", b_ready, gb);
    e.we = 1'b0;
    if (ga || gb) begin
      ta      = ga ? aa : ba;
      td      = ga ? ad : bd;
      e.we    = (ta != '0) && (int'(ta) < int'(NR));
      m_a3    = ta;
      m_wd3   = td;
      m_known = e.we;
      m_prio  = ga ? 1'b1 : 1'b0;
    end
    e.chk = m_known;
    e.a   = m_a3;
    e.d   = m_wd3;
    sb.push_back(e);
    @(posedge clk); #1;
    pop_check();
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    #12;
    apply_reset(1);
    clear_seq(NR, 1'b0);

    // Single A write
    run_cycle(1'b1, 5'd5, 32'h6, 1'b0, '0, '0);
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // B write to x0 is accepted but suppressed; pointer returns to A
    run_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // Both valid held: A,B,A,B, no bubbles
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 5'd6, 32'hA, 1'b1, 5'd7, 32'hB);
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // Randomized mix of single/dual requests and x0 targets
    for (int i = 0; i < 60; i++) begin
      run_cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom(),
                1'($urandom_range(0, 1)), AW'($urandom_range(0, NR - 1)), $urandom());
    end
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    // Reset part-way through clear, then full clear with requests asserted
    @(posedge clk); #1;
    apply_reset(1);
    clear_seq(10, 1'b0);
    #2;
    apply_reset(2);
    clear_seq(NR, 1'b1);

    // Reset with an accepted A write still in flight
    run_cycle(1'b1, 5'd3, 32'h33, 1'b0, '0, '0);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 32'hDEAD_BEEF;
    b_valid = 1'b0;
    #1;
    check("pend_a_ready", a_ready, 1'b1);
    #1;
    apply_reset(2);
    clear_seq(NR, 1'b0);
    run_cycle(1'b1, 5'd3, 32'hC3, 1'b1, 5'd4, 32'hC4);
    run_cycle(1'b1, 5'd3, 32'hC3, 1'b1, 5'd4, 32'hC4);
    run_cycle(1'b0, '0, '0, 1'b0, '0, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
